cpu_bus_responder: RTL
======================

# cpu_bus_responder

Responder side of the 6502 CPU memory bus: decodes every CPU address/write cycle and returns read data one clock later. Owns the 2 KiB work RAM with mirroring, forwards the PPU register window and cartridge PRG space to their ports, and runs the OAM DMA engine. OAM DMA stalls the CPU through `cpu_rdy` and copies one 256-byte page into PPU OAMDATA. Sits between `cpu` and the PPU/cartridge blocks in the NES top level.

## Interface
- `RAM_AW`, default 11: work RAM address width (2^RAM_AW bytes), mirrored across $0000–$1FFF.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `cpu_addr` input 16: CPU address bus.
- `cpu_dout` input 8: CPU write data.
- `cpu_write` input 1: 1 = write cycle.
- `cpu_din` output 8: registered read data to CPU.
- `cpu_rdy` output 1: 0 = CPU must hold its bus state (DMA active).
- `ppu_sel` output 1: PPU register access this cycle (combinational).
- `ppu_reg` output 3: PPU register index.
- `ppu_we` output 1: PPU register write strobe.
- `ppu_wdata` output 8: PPU write data.
- `ppu_rdata` input 8: PPU read data, valid in the same cycle as `ppu_sel`.
- `prg_addr` output 15: PRG address, equal to `cpu_addr[14:0]` or the DMA address.
- `prg_rdata` input 8: PRG read data, combinational from `prg_addr`.

## Operation
- Decode, applied when `cpu_rdy`=1:
  - $0000–$1FFF: RAM at `cpu_addr[RAM_AW-1:0]`.
  - $2000–$3FFF: PPU, `ppu_reg`=`cpu_addr[2:0]`.
  - $4014: DMA trigger, write-only.
  - $8000–$FFFF: PRG.
  - Everything else is unmapped.
- Reads:
  - `cpu_din` is loaded at the clock edge with the RAM, `ppu_rdata` or `prg_rdata` value for the decoded region.
  - Unmapped reads and reads of $4014 hold `cpu_din` (open bus).
- Writes:
  - RAM: RAM is written at the edge.
  - PPU: `ppu_sel`=`ppu_we`=1, `ppu_wdata`=`cpu_dout`.
  - PRG: PRG writes are ignored.
  - `cpu_din` holds on every write cycle.
- `ppu_sel` is asserted only for decoded PPU cycles, never speculatively, because PPU reads have side effects.
- DMA FSM, states IDLE, ALIGN, READ, WRITE:
  - IDLE: a CPU write to $4014 with value V latches page=V, sets idx=0 and moves to ALIGN.
  - ALIGN to READ: one dummy cycle.
  - READ: presents source {page, idx} to RAM/PRG decode and registers the byte into the DMA data register. Unmapped or PPU source reads return the last `cpu_din` and do not assert `ppu_sel`.
  - READ to WRITE: `ppu_sel`=`ppu_we`=1, `ppu_reg`=4, `ppu_wdata`=DMA byte.
  - WRITE: if idx==255 go to IDLE, else increment idx (8-bit) and go to READ.
  - `cpu_rdy`=0 in every state other than IDLE.
- While `cpu_rdy`=0, all CPU inputs are ignored: no RAM/PPU writes, no new trigger, and `cpu_din` holds.
- Reset values:
  - `cpu_din`=0, `cpu_rdy`=1, state IDLE, idx=0, page=0.
  - `ppu_sel`/`ppu_we` are driven 0 whenever `rst`=0.
  - RAM contents are not reset.

## Timing
- Read latency is 1 clock: address in cycle N, `cpu_din` valid from N+1 until the next read edge.
- RAM read-after-write to the same address in the next cycle returns the new data.
- DMA length, for a $4014 write at cycle N:
  - `cpu_rdy` low in cycles N+1 through N+513 (1 ALIGN + 256×2).
  - `cpu_rdy` high at N+514.
  - First OAMDATA write at N+3, last at N+513.
- Reset asserted mid-DMA aborts immediately (asynchronous): `cpu_rdy`=1, no further OAMDATA writes.
- A write to $4014 on the same edge reset deasserts is ignored; the trigger requires `rst`=1 at the sampling edge.

## Configuration
- `BUS_OAM_DMA_EN` defined: DMA FSM present as described.
- `BUS_OAM_DMA_EN` undefined:
  - $4014 is unmapped; writes are ignored and reads are open bus.
  - `cpu_rdy` is tied to 1.
  - No DMA state or counter is synthesized.

## Test plan
- Write $A5 to $0003, then read $0803 and $1803: `cpu_din`=$A5 one cycle after each read address.
- Read $2002 with `ppu_rdata`=$80: `ppu_sel`=1 and `ppu_reg`=2 for exactly one cycle, `ppu_we`=0, `cpu_din`=$80 next cycle. Then read $5000: `cpu_din` stays $80.
- Fill RAM $0200–$02FF with idx^$3C, then write $02 to $4014:
  - `cpu_rdy` low for 513 cycles.
  - Exactly 256 `ppu_we` pulses with `ppu_reg`=4, data $3C, $3D, …, $C3 in order.
  - Any CPU write to $0000 during the stall does not land.
- Write $80 to $4014 with `prg_rdata`=~`prg_addr`[7:0]: `prg_addr` sweeps $0000–$00FF and OAMDATA receives $FF down to $00.
- Pull `rst` low at DMA cycle 100: `cpu_rdy`=1 and `ppu_we`=0 immediately. After release, a read of $0000 works with 1-cycle latency.
- Build without `BUS_OAM_DMA_EN`: write $4014 = $02 → `cpu_rdy` stays 1 and `ppu_we` never pulses.

Source files
------------

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: 6502 bus responder - mirrored work RAM, PPU register window, PRG forwarding, OAM DMA (BUS_OAM_DMA_EN).
// Latency: read data is registered into cpu_din one clock after the address cycle; PPU/PRG strobes are combinational.
// Backpressure: cpu_rdy drops for the whole 513-cycle OAM DMA when BUS_OAM_DMA_EN is defined, otherwise it is tied high.
module cpu_bus_responder #(
    parameter int RAM_AW = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_write,
    output logic [7:0]  cpu_din,
    output logic        cpu_rdy,
    output logic        ppu_sel,
    output logic [2:0]  ppu_reg,
    output logic        ppu_we,
    output logic [7:0]  ppu_wdata,
    input  logic [7:0]  ppu_rdata,
    output logic [14:0] prg_addr,
    input  logic [7:0]  prg_rdata
);
    localparam int RAM_DEPTH = 1 << RAM_AW;

    // CPU-side region decode
    logic ram_hit;
    logic ppu_hit;
    logic prg_hit;

    // DMA engine view seen by the shared datapath
    logic        bus_idle;   // CPU owns the bus
    logic        dma_rd;     // DMA source read cycle
    logic        dma_wr;     // DMA OAMDATA write cycle
    logic [14:0] dma_src;    // low 15 bits of {page, idx}
    logic [7:0]  dma_dat;    // byte waiting to go to OAMDATA

    // Work RAM
    logic [7:0]        ram_q [RAM_DEPTH];
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_rdata;
    logic              ram_we;

    // Registered read data
    logic [7:0] cpu_din_q;
    logic [7:0] cpu_din_d;

    // Decode the CPU address into the mapped regions; everything else is open bus
    always_comb begin
        ram_hit = (cpu_addr[15:13] == 3'b000);
        ppu_hit = (cpu_addr[15:13] == 3'b001);
        prg_hit = cpu_addr[15];
    end

`ifdef BUS_OAM_DMA_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } dma_state_t;

    localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;

    dma_state_t state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] dma_dat_q, dma_dat_d;
    logic       dma_trig;
    logic       src_ram;
    logic       src_prg;
    logic [7:0] src_rdata;

    // Trigger only while the CPU owns the bus; reset holding the flops overrides it
    assign dma_trig = (state_q == ST_IDLE) && cpu_write && (cpu_addr == DMA_TRIG_ADDR);

    // DMA source decode: only RAM and PRG are real sources, PPU/unmapped give open bus
    always_comb begin
        dma_src   = {page_q[6:0], idx_q};
        src_ram   = (page_q[7:5] == 3'b000);
        src_prg   = page_q[7];
        src_rdata = cpu_din_q;
        if (src_ram) begin
            src_rdata = ram_rdata;
        end else if (src_prg) begin
            src_rdata = prg_rdata;
        end
    end

    // DMA state register; reset aborts a transfer immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            page_q    <= 8'h00;
            idx_q     <= 8'h00;
            dma_dat_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            idx_q     <= idx_d;
            dma_dat_q <= dma_dat_d;
        end
    end

    // DMA next-state: one align cycle, then 256 read/write pairs
    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        idx_d     = idx_q;
        dma_dat_d = dma_dat_q;
        case (state_q)
            ST_IDLE: begin
                if (dma_trig) begin
                    page_d  = cpu_dout;
                    idx_d   = 8'h00;
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                state_d = ST_READ;
            end
            ST_READ: begin
                dma_dat_d = src_rdata;
                state_d   = ST_WRITE;
            end
            ST_WRITE: begin
                if (idx_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // DMA outputs: bus ownership and the read/write phase strobes
    always_comb begin
        bus_idle = 1'b0;
        dma_rd   = 1'b0;
        dma_wr   = 1'b0;
        case (state_q)
            ST_IDLE:  bus_idle = 1'b1;
            ST_READ:  dma_rd   = 1'b1;
            ST_WRITE: dma_wr   = 1'b1;
            default:  bus_idle = 1'b0;
        endcase
    end

    assign dma_dat = dma_dat_q;
`else
    // No DMA engine: $4014 falls through to open bus and the CPU is never stalled
    assign bus_idle = 1'b1;
    assign dma_rd   = 1'b0;
    assign dma_wr   = 1'b0;
    assign dma_src  = 15'h0000;
    assign dma_dat  = 8'h00;
`endif

    // RAM port: DMA source address during READ, otherwise the mirrored CPU address
    always_comb begin
        ram_addr  = dma_rd ? dma_src[RAM_AW-1:0] : cpu_addr[RAM_AW-1:0];
        ram_rdata = ram_q[ram_addr];
        ram_we    = bus_idle && cpu_write && ram_hit;
    end

    // Work RAM storage; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_addr] <= cpu_dout;
        end
    end

    // Read data select; writes, stalls and open-bus reads hold the last value
    always_comb begin
        cpu_din_d = cpu_din_q;
        if (bus_idle && !cpu_write) begin
            if (ram_hit) begin
                cpu_din_d = ram_rdata;
            end else if (ppu_hit) begin
                cpu_din_d = ppu_rdata;
            end else if (prg_hit) begin
                cpu_din_d = prg_rdata;
            end
        end
    end

    // Read data register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_din_q <= 8'h00;
        end else begin
            cpu_din_q <= cpu_din_d;
        end
    end

    // PPU and PRG ports: ppu_sel only for real PPU cycles since PPU reads have side effects
    always_comb begin
        ppu_sel   = rst && ((bus_idle && ppu_hit) || dma_wr);
        ppu_we    = rst && ((bus_idle && ppu_hit && cpu_write) || dma_wr);
        ppu_reg   = dma_wr ? 3'd4 : cpu_addr[2:0];
        ppu_wdata = dma_wr ? dma_dat : cpu_dout;
        prg_addr  = dma_rd ? dma_src : cpu_addr[14:0];
    end

    assign cpu_din = cpu_din_q;
    assign cpu_rdy = bus_idle;

endmodule
